cpu_alu_status: RTL and testbench

- Parametrised ALU, adder hold register (ADD) and processor status register (P) for the CPU datapath.
- Sits between the SB/DB/ADL busses and the Decoder. It replaces the constant-zero ADD and P placeholders in the CPU top level.
- Compared with a single-cycle adder, it adds a generic data width, optional two-cycle BCD correction with a ready/valid handshake, and prioritised flag update logic.

---
 rtl/cpu_alu_status_if.sv | 28 ++
 rtl/cpu_alu_status.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_alu_status.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_alu_status_if.sv
// rtl/cpu_alu_status_if.sv - ALU operand/result handshake bundle between Decoder and cpu_alu_status
interface cpu_alu_status_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_ai;
  logic [DATA_WIDTH-1:0] i_bi;
  logic [2:0]            i_op;
  logic                  i_carry_in;
  logic                  i_decimal;
  logic                  i_subtract;
  logic                  i_start;
  logic                  o_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_add;
  logic                  o_acr;
  logic                  o_avr;
  logic                  o_hc;

  modport master (
    output i_ai, i_bi, i_op, i_carry_in, i_decimal, i_subtract, i_start,
    input  o_ready, o_valid, o_add, o_acr, o_avr, o_hc
  );

  modport slave (
    input  i_ai, i_bi, i_op, i_carry_in, i_decimal, i_subtract, i_start,
    output o_ready, o_valid, o_add, o_acr, o_avr, o_hc
  );
endinterface

// File: rtl/cpu_alu_status.sv
// rtl/cpu_alu_status.sv - ALU with ADD hold register, optional two-cycle BCD correction and P register
module cpu_alu_status #(
  parameter int         DATA_WIDTH = 8,
  parameter bit         BCD_ENABLE = 1'b1,
  parameter logic [7:0] P_RESET    = 8'h34
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  cpu_alu_status_if.slave      alu,
  input  logic [7:0]           i_db,
  input  logic                 i_db_p,
  input  logic                 i_db_n_z,
  input  logic                 i_acr_c,
  input  logic                 i_avr_v,
  input  logic                 i_set_c,
  input  logic                 i_clr_c,
  input  logic                 i_set_i,
  input  logic                 i_clr_i,
  input  logic                 i_set_d,
  input  logic                 i_clr_d,
  input  logic                 i_clr_v,
  output logic [7:0]           o_p
);

  localparam int         NIBBLES = DATA_WIDTH / 4;
  localparam int         MSB     = DATA_WIDTH - 1;
  localparam logic [2:0] OP_SUM  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_EOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SR   = 3'd4;

  typedef enum logic {
    IDLE    = 1'b0,
    CORRECT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic                  accept;
  logic                  decimal_req;
  logic [DATA_WIDTH:0]   sum_full;
  logic [NIBBLES-1:0]    nib_carry;
  logic [4:0]            nib_sum;
  logic                  nib_cin;
  logic [DATA_WIDTH-1:0] bin_res;
  logic                  bin_acr;
  logic                  bin_avr;
  logic                  bin_hc;

  logic [DATA_WIDTH-1:0] dec_sum_q;
  logic [NIBBLES-1:0]    dec_carry_q;
  logic                  dec_sub_q;
  logic [DATA_WIDTH-1:0] bcd_res;
  logic                  bcd_acr;
  logic [4:0]            bcd_v;
  logic                  bcd_c;
  logic                  bcd_dc;

  logic [DATA_WIDTH-1:0] add_q;
  logic                  acr_q;
  logic                  avr_q;
  logic                  hc_q;
  logic                  valid_q;
  logic [7:0]            p_q;

  assign accept      = alu.i_start && (state_q == IDLE) && (alu.i_op <= OP_SR);
  assign decimal_req = BCD_ENABLE && (alu.i_op == OP_SUM) && alu.i_decimal;
  assign sum_full    = {1'b0, alu.i_ai} + {1'b0, alu.i_bi} + {{DATA_WIDTH{1'b0}}, alu.i_carry_in};

  // Nibble carries of the binary sum, needed later by the decimal correction.
  always_comb begin
    nib_carry = '0;
    nib_sum   = '0;
    nib_cin   = alu.i_carry_in;
    for (int k = 0; k < NIBBLES; k++) begin
      nib_sum      = {1'b0, alu.i_ai[4*k +: 4]} + {1'b0, alu.i_bi[4*k +: 4]} + {4'b0, nib_cin};
      nib_carry[k] = nib_sum[4];
      nib_cin      = nib_sum[4];
    end
  end

  always_comb begin
    bin_res = '0;
    bin_acr = 1'b0;
    bin_avr = 1'b0;
    bin_hc  = 1'b0;
    case (alu.i_op)
      OP_SUM: begin
        bin_res = sum_full[MSB:0];
        bin_acr = sum_full[DATA_WIDTH];
        bin_avr = (alu.i_ai[MSB] == alu.i_bi[MSB]) && (sum_full[MSB] != alu.i_ai[MSB]);
        bin_hc  = nib_carry[0];
      end
      OP_AND: bin_res = alu.i_ai & alu.i_bi;
      OP_EOR: bin_res = alu.i_ai ^ alu.i_bi;
      OP_OR:  bin_res = alu.i_ai | alu.i_bi;
      OP_SR: begin
        bin_res = {alu.i_carry_in, alu.i_ai[MSB:1]};
        bin_acr = alu.i_ai[0];
      end
      default: ;
    endcase
  end

  // Only the +6 overflow ripples upward; the binary nibble carry has already propagated.
  always_comb begin
    bcd_res = dec_sum_q;
    bcd_v   = '0;
    bcd_c   = 1'b0;
    bcd_dc  = 1'b0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (dec_sub_q) begin
        if (!dec_carry_q[k]) begin
          bcd_res[4*k +: 4] = dec_sum_q[4*k +: 4] - 4'd6;
        end
      end else begin
        bcd_v = {1'b0, dec_sum_q[4*k +: 4]} + {4'b0, bcd_c};
        if (dec_carry_q[k] || (bcd_v > 5'd9)) begin
          bcd_v = bcd_v + 5'd6;
        end
        bcd_res[4*k +: 4] = bcd_v[3:0];
        bcd_c             = bcd_v[4];
        bcd_dc            = dec_carry_q[k] | bcd_v[4];
      end
    end
    bcd_acr = dec_sub_q ? dec_carry_q[NIBBLES-1] : bcd_dc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && decimal_req) state_d = CORRECT;
      CORRECT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      add_q       <= '0;
      acr_q       <= 1'b0;
      avr_q       <= 1'b0;
      hc_q        <= 1'b0;
      valid_q     <= 1'b0;
      dec_sum_q   <= '0;
      dec_carry_q <= '0;
      dec_sub_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == CORRECT) begin
        add_q   <= bcd_res;
        acr_q   <= bcd_acr;
        valid_q <= 1'b1;
      end else if (accept) begin
        if (decimal_req) begin
          dec_sum_q   <= sum_full[MSB:0];
          dec_carry_q <= nib_carry;
          dec_sub_q   <= alu.i_subtract;
          avr_q       <= bin_avr;
          hc_q        <= bin_hc;
        end else begin
          add_q   <= bin_res;
          acr_q   <= bin_acr;
          avr_q   <= bin_avr;
          hc_q    <= bin_hc;
          valid_q <= 1'b1;
        end
      end
    end
  end

  // P transfers see acr_q/avr_q from before this edge, never the result being written now.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      p_q <= P_RESET;
    end else if (i_db_p) begin
      p_q <= i_db | 8'h20;
    end else begin
      if (i_db_n_z) begin
        p_q[7] <= i_db[7];
        p_q[1] <= (i_db == 8'h00);
      end
      if (i_clr_v) begin
        p_q[6] <= 1'b0;
      end else if (i_avr_v) begin
        p_q[6] <= avr_q;
      end
      if (i_set_c ^ i_clr_c) begin
        p_q[0] <= i_set_c;
      end else if (!i_set_c && i_acr_c) begin
        p_q[0] <= acr_q;
      end
      if (i_set_i ^ i_clr_i) p_q[2] <= i_set_i;
      if (i_set_d ^ i_clr_d) p_q[3] <= i_set_d;
      p_q[5] <= 1'b1;
    end
  end

  assign alu.o_ready = (state_q == IDLE);
  assign alu.o_valid = valid_q;
  assign alu.o_add   = add_q;
  assign alu.o_acr   = acr_q;
  assign alu.o_avr   = avr_q;
  assign alu.o_hc    = hc_q;
  assign o_p         = p_q | 8'h20;

endmodule

// File: tb/tb_cpu_alu_status.sv
// tb/tb_cpu_alu_status.sv - randomized self-checking bench for cpu_alu_status against a decimal/integer model
module tb_cpu_alu_status;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_alu_status_if #(.DATA_WIDTH(8))  alu ();
  cpu_alu_status_if #(.DATA_WIDTH(16)) alu16 ();

  logic [7:0] db;
  logic db_p, db_n_z, acr_c, avr_v, set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
  logic [7:0] p;
  logic [7:0] p16;

  cpu_alu_status dut (
    .i_clk(clk), .i_reset(rst), .alu(alu),
    .i_db(db), .i_db_p(db_p), .i_db_n_z(db_n_z), .i_acr_c(acr_c), .i_avr_v(avr_v),
    .i_set_c(set_c), .i_clr_c(clr_c), .i_set_i(set_i), .i_clr_i(clr_i),
    .i_set_d(set_d), .i_clr_d(clr_d), .i_clr_v(clr_v), .o_p(p)
  );

  cpu_alu_status #(.DATA_WIDTH(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .alu(alu16),
    .i_db(8'h00), .i_db_p(1'b0), .i_db_n_z(1'b0), .i_acr_c(1'b0), .i_avr_v(1'b0),
    .i_set_c(1'b0), .i_clr_c(1'b0), .i_set_i(1'b0), .i_clr_i(1'b0),
    .i_set_d(1'b0), .i_clr_d(1'b0), .i_clr_v(1'b0), .o_p(p16)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_add, pend_add, m_p;
  logic       m_acr, m_avr, m_hc, m_valid, m_busy, pend_acr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] rand_bcd();
    logic [3:0] hi, lo;
    hi = 4'($urandom_range(0, 9));
    lo = 4'($urandom_range(0, 9));
    return {hi, lo};
  endfunction

  task automatic model_reset();
    m_add = 8'h00; m_acr = 1'b0; m_avr = 1'b0; m_hc = 1'b0;
    m_valid = 1'b0; m_busy = 1'b0; pend_add = 8'h00; pend_acr = 1'b0;
    m_p = 8'h34;
  endtask

  task automatic model_step();
    logic       pa, pv, cin;
    logic [7:0] ai, bi, nb, np;
    int         s, d;
    pa = m_acr; pv = m_avr; m_valid = 1'b0;
    ai = alu.i_ai; bi = alu.i_bi; cin = alu.i_carry_in;
    if (m_busy) begin
      m_add = pend_add; m_acr = pend_acr; m_busy = 1'b0; m_valid = 1'b1;
    end else if (alu.i_start && alu.i_op <= 3'd4) begin
      s = int'(ai) + int'(bi) + int'(cin);
      if (alu.i_op == 3'd0) begin
        m_avr = (ai[7] == bi[7]) && (((s >> 7) & 1) != int'(ai[7]));
        m_hc  = (int'(ai[3:0]) + int'(bi[3:0]) + int'(cin)) > 15;
        if (alu.i_decimal) begin
          if (alu.i_subtract) begin
            nb = ~bi;
            d = to_dec(ai) - to_dec(nb) - (cin ? 0 : 1);
            pend_acr = (d >= 0);
            if (d < 0) d += 100;
          end else begin
            d = to_dec(ai) + to_dec(bi) + int'(cin);
            pend_acr = (d >= 100);
            d = d % 100;
          end
          pend_add = to_bcd(d);
          m_busy = 1'b1;
        end else begin
          m_add = 8'(s); m_acr = (s > 255); m_valid = 1'b1;
        end
      end else begin
        m_avr = 1'b0; m_hc = 1'b0; m_acr = 1'b0; m_valid = 1'b1;
        case (alu.i_op)
          3'd1: m_add = ai & bi;
          3'd2: m_add = ai ^ bi;
          3'd3: m_add = ai | bi;
          default: begin m_add = (ai >> 1) | (cin ? 8'h80 : 8'h00); m_acr = ai[0]; end
        endcase
      end
    end
    np = m_p;
    if (db_n_z) begin np[7] = db[7]; np[1] = (db == 8'h00); end
    if (acr_c) np[0] = pa;
    if (avr_v) np[6] = pv;
    if (set_c || clr_c) np[0] = (set_c && clr_c) ? m_p[0] : set_c;
    if (set_i != clr_i) np[2] = set_i;
    if (set_d != clr_d) np[3] = set_d;
    if (clr_v) np[6] = 1'b0;
    if (db_p) np = db | 8'h20;
    m_p = np;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("add",   alu.o_add,   m_add);
    check("acr",   alu.o_acr,   m_acr);
    check("avr",   alu.o_avr,   m_avr);
    check("hc",    alu.o_hc,    m_hc);
    check("valid", alu.o_valid, m_valid);
    check("ready", alu.o_ready, !m_busy);
    check("p",     p,           m_p);
  endtask

  task automatic idle_inputs();
    alu.i_start = 0; alu.i_op = 0; alu.i_ai = 0; alu.i_bi = 0;
    alu.i_carry_in = 0; alu.i_decimal = 0; alu.i_subtract = 0;
    db = 0; db_p = 0; db_n_z = 0; acr_c = 0; avr_v = 0;
    set_c = 0; clr_c = 0; set_i = 0; clr_i = 0; set_d = 0; clr_d = 0; clr_v = 0;
  endtask

  task automatic op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                    input logic c, input logic dec, input logic sub);
    alu.i_start = 1; alu.i_op = o; alu.i_ai = a; alu.i_bi = b;
    alu.i_carry_in = c; alu.i_decimal = dec; alu.i_subtract = sub;
  endtask

  initial begin
    idle_inputs();
    alu16.i_start = 0; alu16.i_op = 0; alu16.i_ai = 0; alu16.i_bi = 0;
    alu16.i_carry_in = 0; alu16.i_decimal = 0; alu16.i_subtract = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_add", alu.o_add, 8'h00);
    check("rst_ready", alu.o_ready, 1'b1);
    check("rst_valid", alu.o_valid, 1'b0);
    check("rst_p", p, 8'h34);
    check("rst_p16", p16, 8'h34);

    op(3'd0, 8'h50, 8'h50, 0, 0, 0); cycle();
    check("sum50_add", alu.o_add, 8'hA0); check("sum50_avr", alu.o_avr, 1'b1);
    check("sum50_valid", alu.o_valid, 1'b1);
    op(3'd0, 8'hFF, 8'h01, 0, 0, 0); cycle();
    check("sumff_add", alu.o_add, 8'h00); check("sumff_acr", alu.o_acr, 1'b1);
    check("sumff_avr", alu.o_avr, 1'b0);
    op(3'd1, 8'h3C, 8'h0F, 0, 0, 0); cycle();
    check("b2b_valid", alu.o_valid, 1'b1);

    op(3'd0, 8'h58, 8'h46, 1, 1, 0); cycle();
    check("dadd_ready", alu.o_ready, 1'b0); check("dadd_novalid", alu.o_valid, 1'b0);
    alu.i_start = 0; cycle();
    check("dadd_add", alu.o_add, 8'h05); check("dadd_acr", alu.o_acr, 1'b1);
    check("dadd_valid", alu.o_valid, 1'b1);

    op(3'd0, 8'h42, 8'hEC, 1, 1, 1); cycle();
    op(3'd3, 8'hF0, 8'h0F, 0, 0, 0); cycle();
    check("dsub_add", alu.o_add, 8'h29); check("dsub_acr", alu.o_acr, 1'b1);
    alu.i_start = 0; cycle();
    check("dsub_one_valid", alu.o_valid, 1'b0);

    op(3'd5, 8'h77, 8'h11, 0, 0, 0); cycle();
    check("rsv_valid", alu.o_valid, 1'b0); check("rsv_add", alu.o_add, 8'h29);
    op(3'd4, 8'h03, 8'h00, 1, 0, 0); cycle();
    check("sr_add", alu.o_add, 8'h81); check("sr_acr", alu.o_acr, 1'b1);
    idle_inputs();

    alu16.i_start = 1; alu16.i_ai = 16'h9999; alu16.i_bi = 16'h0001;
    alu16.i_decimal = 1; alu16.i_carry_in = 0;
    cycle();
    alu16.i_start = 0;
    check("w16_ready", alu16.o_ready, 1'b0);
    cycle();
    check("w16_add", alu16.o_add, 16'h0000); check("w16_acr", alu16.o_acr, 1'b1);
    check("w16_valid", alu16.o_valid, 1'b1);

    db_p = 1; db = 8'h00; cycle(); check("dbp_p", p, 8'h20); db_p = 0;
    db_n_z = 1; db = 8'h80; cycle(); check("nz80", p & 8'h82, 8'h80);
    db = 8'h00; cycle(); check("nz00", p & 8'h82, 8'h02); db_n_z = 0;
    set_c = 1; cycle(); set_c = 0; check("setc", p[0], 1'b1);
    set_c = 1; clr_c = 1; cycle(); check("setclr_c", p[0], 1'b1);
    set_c = 0; cycle(); check("clrc", p[0], 1'b0); clr_c = 0;
    op(3'd1, 8'h00, 8'h00, 0, 0, 0); cycle(); alu.i_start = 0;
    set_c = 1; acr_c = 1; cycle(); check("setc_beats_acr", p[0], 1'b1); set_c = 0;
    op(3'd0, 8'hFF, 8'h01, 0, 0, 0); cycle();
    check("acrc_old", p[0], 1'b0); check("acrc_new_acr", alu.o_acr, 1'b1);
    idle_inputs();

    for (int n = 0; n < 400; n++) begin
      logic dec, sub;
      alu.i_start = ($urandom_range(0, 3) != 0);
      alu.i_op = 3'($urandom_range(0, 7));
      dec = (alu.i_op == 3'd0) && ($urandom_range(0, 1) == 1);
      sub = $urandom_range(0, 1);
      alu.i_decimal = dec; alu.i_subtract = sub;
      alu.i_carry_in = $urandom_range(0, 1);
      if (dec) begin
        alu.i_ai = rand_bcd();
        alu.i_bi = sub ? ~rand_bcd() : rand_bcd();
      end else begin
        alu.i_ai = 8'($urandom); alu.i_bi = 8'($urandom);
      end
      db = 8'($urandom);
      db_p = ($urandom_range(0, 9) == 0); db_n_z = ($urandom_range(0, 4) == 0);
      acr_c = ($urandom_range(0, 3) == 0); avr_v = ($urandom_range(0, 3) == 0);
      set_c = ($urandom_range(0, 5) == 0); clr_c = ($urandom_range(0, 5) == 0);
      set_i = ($urandom_range(0, 5) == 0); clr_i = ($urandom_range(0, 5) == 0);
      set_d = ($urandom_range(0, 5) == 0); clr_d = ($urandom_range(0, 5) == 0);
      clr_v = ($urandom_range(0, 5) == 0);
      cycle();
    end
    idle_inputs();

    db_p = 1; db = 8'hFF; cycle(); db_p = 0;
    op(3'd0, 8'h12, 8'h34, 0, 0, 0); cycle();
    op(3'd0, 8'h19, 8'h27, 0, 1, 0); cycle();
    alu.i_start = 0;
    #3;
    rst = 1;
    #1;
    model_reset();
    check("arst_add", alu.o_add, 8'h00); check("arst_p", p, 8'h34);
    check("arst_ready", alu.o_ready, 1'b1); check("arst_valid", alu.o_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 0;
    cycle(); check("arst_no_valid1", alu.o_valid, 1'b0);
    cycle(); check("arst_no_valid2", alu.o_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
